// File: rtl/multicycle_controller_pkg.sv
// Shared definitions for the multicycle controller: state encoding,
// opcode and ALUOp constants, and the per-state control word decode.
package multicycle_controller_pkg;

    typedef enum logic [3:0] {
        S_FETCH    = 4'd0,
        S_DECODE   = 4'd1,
        S_MEMADR   = 4'd2,
        S_MEMRD    = 4'd3,
        S_MEMWB    = 4'd4,
        S_MEMWR    = 4'd5,
        S_EXECUTE  = 4'd6,
        S_ALUWB    = 4'd7,
        S_BRANCH   = 4'd8,
        S_ADDIEXEC = 4'd9,
        S_ADDIWB   = 4'd10,
        S_JUMP     = 4'd11
    } state_t;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_J     = 6'b000010;

    localparam logic [1:0] ALUOP_ADD   = 2'b00;
    localparam logic [1:0] ALUOP_SUB   = 2'b01;
    localparam logic [1:0] ALUOP_FUNCT = 2'b10;

    // Moore control word. wait_mem marks states whose PC/IR strobes are
    // qualified by mem_ready (only FETCH).
    typedef struct packed {
        logic       memwrite;
        logic       iord;
        logic       irwrite;
        logic       regdst;
        logic       memtoreg;
        logic       regwrite;
        logic       alusrca;
        logic [1:0] alusrcb;
        logic [1:0] pcsrc;
        logic [1:0] aluop;
        logic       branch;
        logic       pcwrite;
        logic       wait_mem;
    } ctrl_t;

    function automatic ctrl_t state_ctrl(input state_t s);
        ctrl_t c;
        c = '0;
        case (s)
            S_FETCH: begin
                c.alusrcb  = 2'b01;
                c.aluop    = ALUOP_ADD;
                c.irwrite  = 1'b1;
                c.pcwrite  = 1'b1;
                c.wait_mem = 1'b1;
            end
            S_DECODE: begin
                c.alusrcb = 2'b11;
                c.aluop   = ALUOP_ADD;
            end
            S_MEMADR, S_ADDIEXEC: begin
                c.alusrca = 1'b1;
                c.alusrcb = 2'b10;
                c.aluop   = ALUOP_ADD;
            end
            S_MEMRD: c.iord = 1'b1;
            S_MEMWR: begin
                c.iord     = 1'b1;
                c.memwrite = 1'b1;
            end
            S_MEMWB: begin
                c.memtoreg = 1'b1;
                c.regwrite = 1'b1;
            end
            S_EXECUTE: begin
                c.alusrca = 1'b1;
                c.alusrcb = 2'b00;
                c.aluop   = ALUOP_FUNCT;
            end
            S_ALUWB: begin
                c.regdst   = 1'b1;
                c.regwrite = 1'b1;
            end
            S_ADDIWB: c.regwrite = 1'b1;
            S_BRANCH: begin
                c.alusrca = 1'b1;
                c.alusrcb = 2'b00;
                c.aluop   = ALUOP_SUB;
                c.pcsrc   = 2'b01;
                c.branch  = 1'b1;
            end
            S_JUMP: begin
                c.pcsrc   = 2'b10;
                c.pcwrite = 1'b1;
            end
            default: c = '0;
        endcase
        return c;
    endfunction

endpackage

// File: rtl/multicycle_controller_alu_decoder.sv
// ALU decoder: maps the controller's ALUOp and the funct field onto the
// 3-bit ALU operation code.
module ALU_Decoder
    import multicycle_controller_pkg::*;
(
    input  logic [5:0] funct_i,
    input  logic [1:0] aluop_i,
    output logic [2:0] alucontrol_o
);

    // Only the low funct nibble distinguishes the supported R-type ops.
    logic unused_funct_hi;
    assign unused_funct_hi = ^funct_i[5:4];

    // ALU operation select from ALUOp, falling through to funct for R-type.
    always_comb begin
        alucontrol_o = 3'b010;
        case (aluop_i)
            ALUOP_ADD: alucontrol_o = 3'b010;
            ALUOP_SUB: alucontrol_o = 3'b110;
            default: begin
                case (funct_i[3:0])
                    4'b0000: alucontrol_o = 3'b010;
                    4'b0010: alucontrol_o = 3'b110;
                    4'b0100: alucontrol_o = 3'b000;
                    4'b0101: alucontrol_o = 3'b001;
                    4'b1010: alucontrol_o = 3'b111;
                    default: alucontrol_o = 3'b011;
                endcase
            end
        endcase
    end

endmodule

// File: rtl/multicycle_controller.sv
// Multicycle MIPS-style controller: one state register, Moore control word
// registered alongside it, plus the few strobes that depend on mem_ready,
// Zero and reset.
module multicycle_controller
    import multicycle_controller_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic [5:0] Op,
    input  logic [5:0] Funct,
    input  logic       Zero,
    input  logic       mem_ready,
    output logic       MemWrite,
    output logic       IorD,
    output logic       IRWrite,
    output logic       RegDst,
    output logic       MemtoReg,
    output logic       RegWrite,
    output logic       ALUSrcA,
    output logic       PCEn,
    output logic [1:0] ALUSrcB,
    output logic [1:0] PCSrc,
    output logic [2:0] ALUControl
);

    state_t state_q, state_d;
    ctrl_t  ctrl_q,  ctrl_d;
    logic   mem_go;
    logic   pc_write;

    // Next-state selection.
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_FETCH:    state_d = mem_ready ? S_DECODE : S_FETCH;
            S_DECODE: begin
                case (Op)
                    OP_LW, OP_SW: state_d = S_MEMADR;
                    OP_RTYPE:     state_d = S_EXECUTE;
                    OP_BEQ:       state_d = S_BRANCH;
                    OP_ADDI:      state_d = S_ADDIEXEC;
                    OP_J:         state_d = S_JUMP;
                    default:      state_d = S_FETCH;
                endcase
            end
            S_MEMADR:   state_d = (Op == OP_SW) ? S_MEMWR : S_MEMRD;
            S_MEMRD:    state_d = mem_ready ? S_MEMWB : S_MEMRD;
            S_MEMWR:    state_d = mem_ready ? S_FETCH : S_MEMWR;
            S_EXECUTE:  state_d = S_ALUWB;
            S_ADDIEXEC: state_d = S_ADDIWB;
            default:    state_d = S_FETCH;
        endcase
    end

    // Control word tracks the state it will describe next cycle.
    assign ctrl_d = state_ctrl(state_d);

    // State and registered Moore outputs; reset lands both in FETCH at once.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_FETCH;
            ctrl_q  <= state_ctrl(S_FETCH);
        end else begin
            state_q <= state_d;
            ctrl_q  <= ctrl_d;
        end
    end

    // FETCH strobes wait for the memory; everything else is pure Moore.
    assign mem_go   = ~ctrl_q.wait_mem | mem_ready;
    assign pc_write = ctrl_q.pcwrite & mem_go;

    // Write strobes are held off for the whole time reset is asserted.
    assign IRWrite  = ~rst & ctrl_q.irwrite & mem_go;
    assign PCEn     = ~rst & (pc_write | (ctrl_q.branch & Zero));
    assign MemWrite = ~rst & ctrl_q.memwrite;
    assign RegWrite = ~rst & ctrl_q.regwrite;

    assign IorD     = ctrl_q.iord;
    assign RegDst   = ctrl_q.regdst;
    assign MemtoReg = ctrl_q.memtoreg;
    assign ALUSrcA  = ctrl_q.alusrca;
    assign ALUSrcB  = ctrl_q.alusrcb;
    assign PCSrc    = ctrl_q.pcsrc;

    ALU_Decoder u_alu_dec (
        .funct_i      (Funct),
        .aluop_i      (ctrl_q.aluop),
        .alucontrol_o (ALUControl)
    );

endmodule

// File: tb/tb_multicycle_controller.sv
// Directed bench for multicycle_controller: walks each instruction class
// state by state and compares the full output word against hand-built vectors.
module tb_multicycle_controller;
    import multicycle_controller_pkg::*;

    logic       clk = 1'b0;
    logic       rst;
    logic [5:0] Op, Funct;
    logic       Zero, mem_ready;
    logic       MemWrite, IorD, IRWrite, RegDst, MemtoReg, RegWrite, ALUSrcA, PCEn;
    logic [1:0] ALUSrcB, PCSrc;
    logic [2:0] ALUControl;
    logic [14:0] outs;

    int n_chk  = 0;
    int n_fail = 0;

    multicycle_controller dut (
        .clk        (clk),
        .rst        (rst),
        .Op         (Op),
        .Funct      (Funct),
        .Zero       (Zero),
        .mem_ready  (mem_ready),
        .MemWrite   (MemWrite),
        .IorD       (IorD),
        .IRWrite    (IRWrite),
        .RegDst     (RegDst),
        .MemtoReg   (MemtoReg),
        .RegWrite   (RegWrite),
        .ALUSrcA    (ALUSrcA),
        .PCEn       (PCEn),
        .ALUSrcB    (ALUSrcB),
        .PCSrc      (PCSrc),
        .ALUControl (ALUControl)
    );

    always #5 clk = ~clk;

    // Output word: {MemWrite,IorD,IRWrite,RegDst,MemtoReg,RegWrite,ALUSrcA,PCEn,
    //               ALUSrcB[1:0],PCSrc[1:0],ALUControl[2:0]}
    assign outs = {MemWrite, IorD, IRWrite, RegDst, MemtoReg, RegWrite, ALUSrcA, PCEn,
                   ALUSrcB, PCSrc, ALUControl};

    localparam logic [14:0] E_FETCH   = {8'b0010_0001, 2'b01, 2'b00, 3'b010};
    localparam logic [14:0] E_FSTALL  = {8'b0000_0000, 2'b01, 2'b00, 3'b010};
    localparam logic [14:0] E_DECODE  = {8'b0000_0000, 2'b11, 2'b00, 3'b010};
    localparam logic [14:0] E_MEMADR  = {8'b0000_0010, 2'b10, 2'b00, 3'b010};
    localparam logic [14:0] E_MEMRD   = {8'b0100_0000, 2'b00, 2'b00, 3'b010};
    localparam logic [14:0] E_MEMWB   = {8'b0000_1100, 2'b00, 2'b00, 3'b010};
    localparam logic [14:0] E_MEMWR   = {8'b1100_0000, 2'b00, 2'b00, 3'b010};
    localparam logic [14:0] E_ALUWB   = {8'b0001_0100, 2'b00, 2'b00, 3'b010};
    localparam logic [14:0] E_ADDIWB  = {8'b0000_0100, 2'b00, 2'b00, 3'b010};
    localparam logic [14:0] E_BR_T    = {8'b0000_0011, 2'b00, 2'b01, 3'b110};
    localparam logic [14:0] E_BR_N    = {8'b0000_0010, 2'b00, 2'b01, 3'b110};
    localparam logic [14:0] E_JUMP    = {8'b0000_0001, 2'b00, 2'b10, 3'b010};

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Inputs are already set at the falling edge; check, then advance one cycle.
    task automatic cyc(input string tag, input state_t st, input logic [14:0] exp);
        #1;
        chk({tag, ".state"}, 32'(dut.state_q), 32'(st));
        chk({tag, ".out"}, 32'(outs), 32'(exp));
        @(negedge clk);
    endtask

    logic [5:0] rt_funct [6] = '{6'b101010, 6'b100000, 6'b100010, 6'b100100, 6'b100101, 6'b000111};
    logic [2:0] rt_aluc  [6] = '{3'b111,    3'b010,    3'b110,    3'b000,    3'b001,    3'b011};

    initial begin
        rst = 1'b1; Op = OP_RTYPE; Funct = 6'b0; Zero = 1'b0; mem_ready = 1'b1;
        @(negedge clk);
        #1;
        chk("reset.state", 32'(dut.state_q), 32'(S_FETCH));
        chk("reset.strobes", 32'({IRWrite, PCEn, MemWrite, RegWrite}), 32'd0);
        @(negedge clk);
        rst = 1'b0;

        // lw, no stalls
        Op = OP_LW;
        cyc("lw.fetch",  S_FETCH,  E_FETCH);
        cyc("lw.decode", S_DECODE, E_DECODE);
        cyc("lw.memadr", S_MEMADR, E_MEMADR);
        cyc("lw.memrd",  S_MEMRD,  E_MEMRD);
        cyc("lw.memwb",  S_MEMWB,  E_MEMWB);

        // sw, three-cycle memory stall in MEMWR
        Op = OP_SW;
        cyc("sw.fetch",  S_FETCH,  E_FETCH);
        cyc("sw.decode", S_DECODE, E_DECODE);
        cyc("sw.memadr", S_MEMADR, E_MEMADR);
        mem_ready = 1'b0;
        for (int i = 0; i < 3; i++) cyc("sw.memwr_stall", S_MEMWR, E_MEMWR);
        mem_ready = 1'b1;
        cyc("sw.memwr", S_MEMWR, E_MEMWR);

        // beq taken; Zero high in DECODE must not raise PCEn
        Op = OP_BEQ; Zero = 1'b1;
        cyc("beqt.fetch",  S_FETCH,  E_FETCH);
        cyc("beqt.decode", S_DECODE, E_DECODE);
        cyc("beqt.branch", S_BRANCH, E_BR_T);
        Zero = 1'b0;
        cyc("beqn.fetch",  S_FETCH,  E_FETCH);
        cyc("beqn.decode", S_DECODE, E_DECODE);
        cyc("beqn.branch", S_BRANCH, E_BR_N);

        // R-type across the funct table
        Op = OP_RTYPE;
        for (int i = 0; i < 6; i++) begin
            Funct = rt_funct[i];
            cyc("rt.fetch",   S_FETCH,   E_FETCH);
            cyc("rt.decode",  S_DECODE,  E_DECODE);
            cyc("rt.execute", S_EXECUTE, {8'b0000_0010, 2'b00, 2'b00, rt_aluc[i]});
            cyc("rt.aluwb",   S_ALUWB,   E_ALUWB);
        end

        // addi with mem_ready low outside FETCH, then a FETCH stall
        Op = OP_ADDI;
        cyc("addi.fetch", S_FETCH, E_FETCH);
        mem_ready = 1'b0;
        cyc("addi.decode", S_DECODE,   E_DECODE);
        cyc("addi.exec",   S_ADDIEXEC, E_MEMADR);
        cyc("addi.wb",     S_ADDIWB,   E_ADDIWB);
        cyc("fstall.1",    S_FETCH,    E_FSTALL);
        cyc("fstall.2",    S_FETCH,    E_FSTALL);
        mem_ready = 1'b1;

        // j
        Op = OP_J;
        cyc("j.fetch",  S_FETCH,  E_FETCH);
        cyc("j.decode", S_DECODE, E_DECODE);
        cyc("j.jump",   S_JUMP,   E_JUMP);

        // unknown opcode falls straight back to FETCH
        Op = 6'b111111;
        cyc("bad.fetch",  S_FETCH,  E_FETCH);
        cyc("bad.decode", S_DECODE, E_DECODE);
        Op = OP_LW;

        // reset pulsed mid-MEMRD
        cyc("rlw.fetch",  S_FETCH,  E_FETCH);
        cyc("rlw.decode", S_DECODE, E_DECODE);
        cyc("rlw.memadr", S_MEMADR, E_MEMADR);
        mem_ready = 1'b0;
        #1;
        chk("rlw.memrd.state", 32'(dut.state_q), 32'(S_MEMRD));
        #1;
        rst = 1'b1; mem_ready = 1'b1;
        #1;
        chk("rst.async.state", 32'(dut.state_q), 32'(S_FETCH));
        chk("rst.async.strobes", 32'({IRWrite, PCEn, MemWrite, RegWrite}), 32'd0);
        @(negedge clk);
        #1;
        chk("rst.hold.state", 32'(dut.state_q), 32'(S_FETCH));
        chk("rst.hold.strobes", 32'({IRWrite, PCEn, MemWrite, RegWrite}), 32'd0);
        rst = 1'b0;
        cyc("post.fetch",  S_FETCH,  E_FETCH);
        cyc("post.decode", S_DECODE, E_DECODE);
        cyc("post.memadr", S_MEMADR, E_MEMADR);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/multicycle_controller.md
MULTICYCLE_CONTROLLER -- requirements
Module: multicycle_controller

Interface
REQ-001 The block SHALL have these ports: clk, input, 1, sole clock, all state on rising edge.
REQ-002 rst, input, 1, asynchronous active-high reset.
REQ-003 Op, input, 6, instruction opcode field from the instruction register.
REQ-004 Funct, input, 6, instruction funct field from the instruction register.
REQ-005 Zero, input, 1, ALU zero flag.
REQ-006 mem_ready, input, 1, memory access complete this cycle.
REQ-007 Control outputs, all 1 bit: MemWrite, IorD, IRWrite, RegDst, MemtoReg, RegWrite, ALUSrcA, PCEn.
REQ-008 ALUSrcB, output, 2, ALU B-operand select.
REQ-009 PCSrc, output, 2, PC source select.
REQ-010 ALUControl, output, 3, ALU operation code.

Function
REQ-011 States SHALL be FETCH, DECODE, MEMADR, MEMRD, MEMWB, MEMWR, EXECUTE, ALUWB, BRANCH, ADDIEXEC, ADDIWB and JUMP, registered in one state register.
REQ-012 Opcodes SHALL be R-type 000000, lw 100011, sw 101011, beq 000100, addi 001000 and j 000010.
REQ-013 FETCH SHALL go to DECODE when mem_ready=1 and SHALL stay in FETCH otherwise.
REQ-014 DECODE SHALL go to MEMADR for lw/sw, EXECUTE for R-type, BRANCH for beq, ADDIEXEC for addi, JUMP for j, and FETCH for any other opcode.
REQ-015 Remaining transitions SHALL be: MEMADR->MEMRD (lw) or MEMWR (sw); MEMRD->MEMWB on mem_ready, else hold; MEMWR->FETCH on mem_ready, else hold; EXECUTE->ALUWB; ADDIEXEC->ADDIWB; MEMWB, ALUWB, ADDIWB, BRANCH and JUMP->FETCH.
REQ-016 Outputs are Moore, decoded from state only, except where stated; any output not listed below for a state SHALL be 0.
REQ-017 FETCH: ALUSrcB=01, ALUOp=00; IRWrite=1 and PC write only when mem_ready=1.
REQ-018 DECODE: ALUSrcB=11, ALUOp=00.
REQ-019 MEMADR and ADDIEXEC: ALUSrcA=1, ALUSrcB=10, ALUOp=00.
REQ-020 MEMRD: IorD=1.
REQ-021 MEMWR: IorD=1, MemWrite=1 for every cycle spent in the state.
REQ-022 MEMWB: MemtoReg=1, RegWrite=1.
REQ-023 EXECUTE: ALUSrcA=1, ALUSrcB=00, ALUOp=10.
REQ-024 ALUWB: RegDst=1, RegWrite=1.
REQ-025 ADDIWB: RegWrite=1.
REQ-026 BRANCH: ALUSrcA=1, ALUSrcB=00, ALUOp=01, PCSrc=01, Branch=1.
REQ-027 JUMP: PCSrc=10, PC write=1.
REQ-028 PCEn SHALL equal PC write OR (Branch AND Zero), combinationally from the current-cycle Zero.
REQ-029 ALUOp SHALL be internal and SHALL map to ALUControl as follows.
- 00 -> 010.
- 01 -> 110.
- 10 -> from Funct[3:0]: 0000->010, 0010->110, 0100->000, 0101->001, 1010->111, any other value->011.
REQ-030 Latencies with mem_ready always 1 SHALL be: lw 5 cycles, sw 4, R-type 4, addi 4, beq 3, j 3.
REQ-031 A mem_ready stall SHALL hold every output at its state value; IRWrite and PC write SHALL stay 0 during a FETCH stall.
REQ-032 mem_ready asserted in a state that does not wait for it SHALL have no effect.

Reset
REQ-033 When rst=1 the state SHALL become FETCH immediately (asynchronously), including mid-instruction or during a stall.
REQ-034 While rst=1, IRWrite, PCEn, MemWrite and RegWrite SHALL be forced to 0.
REQ-035 The first FETCH after rst deasserts SHALL behave as a normal fetch.

Structure
REQ-036 A shared package SHALL hold the state encoding (4-bit enum), the opcode constants and the ALUOp constants.
REQ-037 ALUControl SHALL come from one instantiated sub-module, ALU_Decoder, driven by Funct and the internal ALUOp.

Verification
REQ-038 lw (Op=100011), mem_ready=1: states FETCH, DECODE, MEMADR, MEMRD, MEMWB, FETCH; RegWrite=1 and MemtoReg=1 only in cycle 5.
REQ-039 sw with mem_ready=0 for 3 cycles in MEMWR: MemWrite=1 for 4 consecutive cycles, then FETCH.
REQ-040 beq, Zero=1 in BRANCH: PCEn=1, PCSrc=01; Zero=0 gives PCEn=0, and both cases return to FETCH.
REQ-041 R-type, Funct=101010: in EXECUTE ALUControl=111; ALUWB has RegDst=1, RegWrite=1.
REQ-042 Op=111111: FETCH, DECODE, FETCH, with no RegWrite, MemWrite or PCEn other than at fetch.
REQ-043 rst pulsed mid-MEMRD (between clock edges): state is FETCH at once, and write strobes are 0 while rst=1.
